// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: one request at a time, MOV/MOC handshake to ram256x8, alignment/range checks, load extension.
// Latency: DONE 4 edges after accept with a 1-cycle MOC, 1 edge for rejected requests; REQ outside IDLE is ignored.
module mem_access_ctrl #(
   parameter int ADDR_LIMIT = 256,
   parameter int TIMEOUT    = 15
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REQ,
   input  logic        REQ_RW,
   input  logic [1:0]  REQ_SIZE,
   input  logic        REQ_SIGNED,
   input  logic [31:0] REQ_ADDR,
   input  logic [31:0] REQ_WDATA,
   output logic        MOV,
   output logic        ReadWrite,
   output logic [2:0]  MS_2_0,
   output logic [31:0] DataIn,
   output logic [31:0] Address,
   input  logic        MOC,
   input  logic [31:0] DataOut,
   output logic        BUSY,
   output logic        DONE,
   output logic [1:0]  ERR,
   output logic [31:0] RDATA
);

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RELEASE, FINISH} state_t;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_ALIGN = 2'b01;
   localparam logic [1:0] ERR_RANGE = 2'b10;
   localparam logic [1:0] ERR_TMO   = 2'b11;

   state_t      state, state_nxt;
   logic [3:0]  tmo_cnt;
   logic        tmo_hit;
   logic        sgn_q;
   logic        misaligned;
   logic        out_of_range;
   logic [1:0]  span;
   logic [1:0]  req_err;
   logic [32:0] last_byte;
   logic [31:0] load_ext;

   // Request check works on the live REQ_* inputs so the IDLE decision is made in the accept cycle.
   always_comb begin
      span       = 2'd3;
      misaligned = 1'b1;
      case (REQ_SIZE)
         2'b00: begin span = 2'd0; misaligned = 1'b0;          end
         2'b01: begin span = 2'd1; misaligned = REQ_ADDR[0];   end
         2'b10: begin span = 2'd3; misaligned = |REQ_ADDR[1:0]; end
         default: begin span = 2'd3; misaligned = 1'b1;        end
      endcase
      last_byte    = {1'b0, REQ_ADDR} + {31'd0, span};
      out_of_range = (last_byte >= 33'(ADDR_LIMIT));
      if (misaligned)
         req_err = ERR_ALIGN;
      else if (out_of_range)
         req_err = ERR_RANGE;
      else
         req_err = ERR_OK;
   end

   always_comb begin
      case (MS_2_0[1:0])
         2'b00:   load_ext = {{24{sgn_q & DataOut[7]}}, DataOut[7:0]};
         2'b01:   load_ext = {{16{sgn_q & DataOut[15]}}, DataOut[15:0]};
         default: load_ext = DataOut;
      endcase
   end

   assign tmo_hit = (tmo_cnt == 4'(TIMEOUT - 1));

   always_ff @(posedge CLK) begin
      if (RESET)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      MOV       = 1'b0;
      BUSY      = 1'b1;
      DONE      = 1'b0;
      case (state)
         IDLE: begin
            BUSY = 1'b0;
            if (REQ)
               state_nxt = (req_err != ERR_OK) ? FINISH : SETUP;
         end
         SETUP:   state_nxt = ACCESS;
         ACCESS: begin
            MOV = 1'b1;
            if (MOC)
               state_nxt = RELEASE;
            else if (tmo_hit)
               state_nxt = FINISH;
         end
         RELEASE: begin
            if (!MOC)
               state_nxt = FINISH;
         end
         FINISH: begin
            DONE      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Bus-facing fields stay latched after DONE; only a new accepted request changes them.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         Address   <= 32'd0;
         DataIn    <= 32'd0;
         ReadWrite <= 1'b1;
         MS_2_0    <= 3'b000;
         sgn_q     <= 1'b0;
         ERR       <= ERR_OK;
         RDATA     <= 32'd0;
         tmo_cnt   <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (REQ) begin
                  Address   <= REQ_ADDR;
                  DataIn    <= REQ_WDATA;
                  ReadWrite <= REQ_RW;
                  MS_2_0    <= {1'b0, REQ_SIZE};
                  sgn_q     <= REQ_SIGNED;
                  ERR       <= req_err;
               end
            end
            SETUP: tmo_cnt <= 4'd0;
            ACCESS: begin
               tmo_cnt <= tmo_cnt + 4'd1;
               if (MOC) begin
                  if (ReadWrite)
                     RDATA <= load_ext;
               end else if (tmo_hit) begin
                  ERR <= ERR_TMO;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: RAM responder, transaction-level model and a per-cycle output checker.
module tb_mem_access_ctrl;

   localparam int TO = 15;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        REQ;
   logic        REQ_RW;
   logic [1:0]  REQ_SIZE;
   logic        REQ_SIGNED;
   logic [31:0] REQ_ADDR;
   logic [31:0] REQ_WDATA;
   logic        MOV;
   logic        ReadWrite;
   logic [2:0]  MS_2_0;
   logic [31:0] DataIn;
   logic [31:0] Address;
   logic        MOC;
   logic [31:0] DataOut;
   logic        BUSY;
   logic        DONE;
   logic [1:0]  ERR;
   logic [31:0] RDATA;

   mem_access_ctrl #(.ADDR_LIMIT(256), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_RW(REQ_RW), .REQ_SIZE(REQ_SIZE),
      .REQ_SIGNED(REQ_SIGNED), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
      .MOV(MOV), .ReadWrite(ReadWrite), .MS_2_0(MS_2_0), .DataIn(DataIn), .Address(Address),
      .MOC(MOC), .DataOut(DataOut), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          a;      // accept edge
      int          len;    // edges from accept to FINISH entry
      int          mov_n;  // cycles MOV is high
      logic [1:0]  err;
      logic [31:0] rdata;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rw;
      logic [2:0]  ms;
      bit          dflt;
   } txn_t;

   txn_t        q[$];
   txn_t        last;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          prev_end = -1000;
   bit          started = 1'b0;
   logic [7:0]  ram [256];
   logic [7:0]  ref_mem [256];
   int          ram_wait = 0;
   int          ram_hold = 0;
   bit          ram_nores = 1'b0;
   int          mov_cnt = 0;
   int          hold_cnt = 0;
   logic [31:0] model_rdata = 32'd0;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic txn_t reset_txn();
      txn_t t;
      t.a = -1000; t.len = 0; t.mov_n = 0; t.err = 2'b00; t.rdata = 32'd0;
      t.addr = 32'd0; t.wdata = 32'd0; t.rw = 1'b1; t.ms = 3'b000; t.dflt = 1'b1;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [1:0] model_err(input logic [1:0] size, input logic [31:0] addr);
      longint a64;
      a64 = longint'({32'd0, addr});
      if (size == 2'b11 || (a64 % longint'(nbytes(size))) != 0) return 2'b01;
      if (a64 + longint'(nbytes(size)) - 1 >= 256) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
      int     n;
      longint v;
      n = nbytes(size);
      v = 0;
      for (int i = n - 1; i >= 0; i--)
         v = v * 256 + longint'(ref_mem[8'(addr + 32'(i))]);
      if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1)))
         v = v - (longint'(1) << (8 * n));
      return 32'(v);
   endfunction

   task automatic model_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
      for (int i = 0; i < nbytes(size); i++)
         ref_mem[8'(addr + 32'(i))] = 8'(wdata >> (8 * i));
   endtask

   // RAM responder: raises MOC after ram_wait extra MOV cycles, holds it ram_hold cycles after MOV drops.
   always @(posedge CLK) begin
      #1;
      if (MOV && !MOC && !ram_nores) begin
         if (mov_cnt == ram_wait) begin
            MOC = 1'b1;
            hold_cnt = 0;
            if (ReadWrite) begin
               DataOut = {ram[8'(Address + 32'd3)], ram[8'(Address + 32'd2)],
                          ram[8'(Address + 32'd1)], ram[Address[7:0]]};
            end else begin
               for (int i = 0; i < nbytes(MS_2_0[1:0]); i++)
                  ram[8'(Address + 32'(i))] = 8'(DataIn >> (8 * i));
            end
         end else begin
            mov_cnt++;
         end
      end else if (MOC && !MOV) begin
         if (hold_cnt == ram_hold) begin
            MOC = 1'b0;
            mov_cnt = 0;
         end else begin
            hold_cnt++;
         end
      end else if (!MOV && !MOC) begin
         mov_cnt = 0;
      end
   end

   // Per-cycle checker against the transaction model.
   always @(negedge CLK) begin
      txn_t cur;
      bit   in_win, e_busy, e_done, e_mov;
      if (started) begin
         while (q.size() > 0 && cyc > q[0].a + q[0].len) begin
            last = q[0];
            void'(q.pop_front());
         end
         in_win = (q.size() > 0) && (q[0].a <= cyc);
         cur    = in_win ? q[0] : last;
         e_busy = in_win;
         e_done = in_win && (cyc == cur.a + cur.len);
         e_mov  = in_win && (cyc >= cur.a + 1) && (cyc <= cur.a + cur.mov_n);
         chk("busy", 32'(BUSY), 32'(e_busy));
         chk("done", 32'(DONE), 32'(e_done));
         chk("mov", 32'(MOV), 32'(e_mov));
         chk("address", Address, cur.addr);
         chk("datain", DataIn, cur.wdata);
         chk("readwrite", 32'(ReadWrite), 32'(cur.rw));
         chk("ms_2_0", 32'(MS_2_0), 32'(cur.ms));
         if (e_done) begin
            chk("err", 32'(ERR), 32'(cur.err));
            chk("rdata_done", RDATA, cur.rdata);
         end
         if (!in_win) begin
            chk("rdata_idle", RDATA, cur.rdata);
            if (cur.dflt) chk("err_reset", 32'(ERR), 32'd0);
         end
      end
   end

   // pin: 0 none, 1 check model error code against hand value, 2 also model load data
   task automatic issue(input logic rw, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int w, input int h, input bit nores, input bit hold,
                        input int pin, input logic [1:0] hand_err, input logic [31:0] hand_rdata);
      txn_t t;
      int   guard;
      @(posedge CLK); #1;
      guard = 0;
      while (cyc < prev_end + 1 && guard < 200) begin
         @(posedge CLK); #1;
         guard++;
      end
      if (guard >= 200) begin
         n_cmp++; n_bad++;
         $display("FAIL idle_wait @cyc %0d: got still busy, expected idle", cyc);
      end
      t.err = model_err(size, addr);
      t.a = cyc + 1; t.addr = addr; t.wdata = wdata; t.rw = rw;
      t.ms = {1'b0, size}; t.dflt = 1'b0;
      if (t.err != 2'b00) begin
         t.len = 0; t.mov_n = 0;
      end else if (nores) begin
         t.len = TO + 1; t.mov_n = TO;
         t.err = 2'b11;
      end else begin
         t.len = 3 + w + h; t.mov_n = 1 + w;
         if (rw) model_rdata = model_load(size, sgn, addr);
         else    model_store(size, addr, wdata);
      end
      t.rdata = model_rdata;
      ram_wait = w; ram_hold = h; ram_nores = nores;
      q.push_back(t);
      prev_end = t.a + t.len;
      REQ_RW = rw; REQ_SIZE = size; REQ_SIGNED = sgn; REQ_ADDR = addr; REQ_WDATA = wdata;
      REQ = 1'b1;
      @(posedge CLK); #1;
      if (!hold) REQ = 1'b0;
      if (pin >= 1) chk("pin_err", 32'(t.err), 32'(hand_err));
      if (pin >= 2) chk("pin_rdata", t.rdata, hand_rdata);
   endtask

   task automatic mid_reset();
      RESET = 1'b1;
      @(posedge CLK);
      q.delete();
      last = reset_txn();
      model_rdata = 32'd0;
      prev_end = -1000;
      #1 RESET = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog @cyc %0d: got no finish, expected finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i] = 8'(i * 7 + 13);
         ref_mem[i] = ram[i];
      end
      ram[0] = 8'hF0; ref_mem[0] = 8'hF0;
      last = reset_txn();
      RESET = 1'b1; REQ = 1'b0; REQ_RW = 1'b0; REQ_SIZE = 2'b00; REQ_SIGNED = 1'b0;
      REQ_ADDR = 32'd0; REQ_WDATA = 32'd0; MOC = 1'b0; DataOut = 32'd0;
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      started = 1'b1;

      // byte loads, signed and unsigned
      issue(1'b1, 2'b00, 1'b1, 32'd0, 32'd0, 0, 0, 1'b0, 1'b0, 2, 2'b00, 32'hFFFF_FFF0);
      issue(1'b1, 2'b00, 1'b0, 32'd0, 32'd0, 0, 0, 1'b0, 1'b0, 2, 2'b00, 32'h0000_00F0);

      // stores with slow RAM, then readbacks
      issue(1'b0, 2'b01, 1'b0, 32'd30, 32'h8181, 1, 1, 1'b0, 1'b0, 1, 2'b00, 32'd0);
      issue(1'b1, 2'b01, 1'b1, 32'd30, 32'd0, 0, 0, 1'b0, 1'b0, 2, 2'b00, 32'hFFFF_8181);
      issue(1'b0, 2'b10, 1'b0, 32'd100, 32'h1234_5678, 2, 0, 1'b0, 1'b0, 1, 2'b00, 32'd0);
      issue(1'b1, 2'b10, 1'b1, 32'd100, 32'd0, 0, 2, 1'b0, 1'b0, 2, 2'b00, 32'h1234_5678);
      issue(1'b1, 2'b00, 1'b1, 32'd101, 32'd0, 0, 0, 1'b0, 1'b0, 2, 2'b00, 32'h0000_0056);
      issue(1'b1, 2'b01, 1'b0, 32'd102, 32'd0, 0, 0, 1'b0, 1'b0, 2, 2'b00, 32'h0000_1234);

      // alignment and range boundaries
      issue(1'b1, 2'b10, 1'b0, 32'd26,  32'd0, 0, 0, 1'b0, 1'b0, 1, 2'b01, 32'd0);
      issue(1'b1, 2'b10, 1'b0, 32'd252, 32'd0, 0, 0, 1'b0, 1'b0, 1, 2'b00, 32'd0);
      issue(1'b1, 2'b01, 1'b0, 32'd253, 32'd0, 0, 0, 1'b0, 1'b0, 1, 2'b01, 32'd0);
      issue(1'b0, 2'b10, 1'b0, 32'd254, 32'hDEAD, 0, 0, 1'b0, 1'b0, 1, 2'b01, 32'd0);
      issue(1'b1, 2'b00, 1'b1, 32'd255, 32'd0, 0, 0, 1'b0, 1'b0, 1, 2'b00, 32'd0);
      issue(1'b1, 2'b00, 1'b0, 32'd256, 32'd0, 0, 0, 1'b0, 1'b0, 1, 2'b10, 32'd0);
      issue(1'b1, 2'b11, 1'b0, 32'd256, 32'd0, 0, 0, 1'b0, 1'b0, 1, 2'b01, 32'd0);
      issue(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'd0, 0, 0, 1'b0, 1'b0, 1, 2'b10, 32'd0);

      // timeout, with stray REQ pulses while busy
      issue(1'b1, 2'b10, 1'b0, 32'd4, 32'd0, 0, 0, 1'b1, 1'b0, 1, 2'b11, 32'd0);
      repeat (3) begin @(posedge CLK); #1; end
      REQ_ADDR = 32'd64; REQ_RW = 1'b0; REQ = 1'b1;
      @(posedge CLK); #1;
      REQ = 1'b0;

      // reset mid-ACCESS, then a normal request
      issue(1'b1, 2'b10, 1'b0, 32'd8, 32'd0, 0, 0, 1'b1, 1'b0, 0, 2'b00, 32'd0);
      repeat (2) begin @(posedge CLK); #1; end
      mid_reset();
      issue(1'b1, 2'b10, 1'b0, 32'd8, 32'd0, 0, 0, 1'b0, 1'b0, 0, 2'b00, 32'd0);

      // back-to-back word loads with REQ held high
      issue(1'b1, 2'b10, 1'b0, 32'd0, 32'd0, 0, 0, 1'b0, 1'b1, 0, 2'b00, 32'd0);
      issue(1'b1, 2'b10, 1'b0, 32'd4, 32'd0, 0, 0, 1'b0, 1'b1, 0, 2'b00, 32'd0);
      issue(1'b1, 2'b10, 1'b0, 32'd8, 32'd0, 0, 0, 1'b0, 1'b0, 0, 2'b00, 32'd0);

      repeat (10) @(posedge CLK);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
